// File: rtl/serial_adder_if.sv
// Handshake/result bundle for serial_adder. The ovf signal and its modport
// entries exist only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
`else
  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder built around one full_adderV cell and a carry flop.
// Optional signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN.

module full_adderV (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic fsum,
  output logic fcarry_out
);
  assign fsum       = a ^ b ^ c;
  assign fcarry_out = (a & b) | (c & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Holds the WIDTH-1 sum bits already produced; the final bit joins on the last step.
  logic [WIDTH-2:0] s_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  logic             fsum;
  logic             fcarry_out;
  logic [WIDTH-1:0] sum_next;

  full_adderV u_fa (
    .a          (a_sh[0]),
    .b          (b_sh[0]),
    .c          (carry),
    .fsum       (fsum),
    .fcarry_out (fcarry_out)
  );

  assign sum_next = {fsum, s_sh};

  // Controller and datapath: one state register set with Moore busy/done outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= {WIDTH{1'b0}};
      b_sh  <= {WIDTH{1'b0}};
      s_sh  <= {(WIDTH-1){1'b0}};
      carry <= 1'b0;
      cnt   <= {CW{1'b0}};
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= {WIDTH{1'b0}};
      cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.start) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            carry <= bus.cin;
            cnt   <= {CW{1'b0}};
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          s_sh  <= sum_next[WIDTH-1:1];
          a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
          carry <= fcarry_out;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST_BIT) begin
            sum   <= sum_next;
            cout  <= fcarry_out;
`ifdef SERIAL_ADDER_OVF_EN
            // carry still holds the carry into the MSB on this step
            ovf   <= carry ^ fcarry_out;
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            busy  <= 1'b1;
            done  <= 1'b0;
            state <= RUN;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.sum  = sum;
  assign bus.cout = cout;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf  = ovf;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8).
module tb_serial_adder;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  serial_adder_if #(.WIDTH(8)) bus ();

  serial_adder #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                       input logic [7:0] es, input logic ec, input logic eo);
    int n;
    bus.start = 1'b1; bus.a = ta; bus.b = tb_v; bus.cin = tc;
    step();
    bus.start = 1'b0; bus.a = ~ta; bus.b = 8'h5A; bus.cin = ~tc;
    n = 0;
    while (bus.done !== 1'b1 && n < 20) begin
      chk("busy_in_run", {31'd0, bus.busy}, 32'd1);
      step();
      n++;
    end
    chk("done_seen", {31'd0, bus.done}, 32'd1);
    chk("latency", n, 32'd8);
    chk("busy_in_done", {31'd0, bus.busy}, 32'd0);
    chk("sum", {24'd0, bus.sum}, {24'd0, es});
    chk("cout", {31'd0, bus.cout}, {31'd0, ec});
`ifdef SERIAL_ADDER_OVF_EN
    chk("ovf", {31'd0, bus.ovf}, {31'd0, eo});
`else
    if (eo !== 1'bx) n = 0;
`endif
    step();
    chk("done_fall", {31'd0, bus.done}, 32'd0);
    chk("busy_idle", {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    int pulses;
    int busy_seen;
    int e;
    int last_e;
    int first_e;
    total = 0; bad = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.a = 8'h00; bus.b = 8'h00; bus.cin = 1'b0;
    step(); step();
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_sum", {24'd0, bus.sum}, 32'd0);
    chk("rst_cout", {31'd0, bus.cout}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst_ovf", {31'd0, bus.ovf}, 32'd0);
`endif
    rst = 1'b0;
    step();

    // Scenarios 1 and 2
    do_op(8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    do_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

    // Scenario 3: start pulses during RUN and DONE are ignored
    bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h20; bus.cin = 1'b0;
    step();
    bus.start = 1'b0;
    step(); step();
    bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'h55;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("ign_done", {31'd0, bus.done}, 32'd1);
    chk("ign_sum", {24'd0, bus.sum}, 32'h30);
    chk("ign_cout", {31'd0, bus.cout}, 32'd0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("ign_done_fall", {31'd0, bus.done}, 32'd0);
    chk("ign_busy", {31'd0, bus.busy}, 32'd0);
    pulses = 0; busy_seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.done === 1'b1) pulses++;
      if (bus.busy === 1'b1) busy_seen++;
    end
    chk("ign_no_done", pulses, 32'd0);
    chk("ign_no_busy", busy_seen, 32'd0);
    chk("ign_sum_held", {24'd0, bus.sum}, 32'h30);

    // Scenario 4: reset mid-RUN aborts
    bus.start = 1'b1; bus.a = 8'h81; bus.b = 8'h81; bus.cin = 1'b0;
    step();
    bus.start = 1'b0;
    step(); step(); step();
    chk("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, bus.busy}, 32'd0);
    chk("arst_done", {31'd0, bus.done}, 32'd0);
    chk("arst_sum", {24'd0, bus.sum}, 32'd0);
    chk("arst_cout", {31'd0, bus.cout}, 32'd0);
    step();
    rst = 1'b0;
    pulses = 0; busy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.done === 1'b1) pulses++;
      if (bus.busy === 1'b1) busy_seen++;
    end
    chk("post_rst_no_done", pulses, 32'd0);
    chk("post_rst_no_busy", busy_seen, 32'd0);
    do_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

    // Scenario 5: start held high gives back-to-back operations
    bus.start = 1'b1; bus.a = 8'h0F; bus.b = 8'hF0; bus.cin = 1'b1;
    step();
    e = 0; pulses = 0; last_e = 0; first_e = 0;
    while (pulses < 3 && e < 40) begin
      step();
      e++;
      if (bus.done === 1'b1) begin
        chk("b2b_sum", {24'd0, bus.sum}, 32'h00);
        chk("b2b_cout", {31'd0, bus.cout}, 32'd1);
        if (pulses == 0) first_e = e;
        else chk("b2b_spacing", e - last_e, 32'd10);
        last_e = e;
        pulses++;
      end
    end
    bus.start = 1'b0;
    chk("b2b_pulses", pulses, 32'd3);
    chk("b2b_first", first_e, 32'd8);
    step(); step();
    chk("b2b_idle_busy", {31'd0, bus.busy}, 32'd0);

`ifdef SERIAL_ADDER_OVF_EN
    // Scenario 6: signed overflow
    do_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    do_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    do_op(8'h40, 8'h20, 1'b0, 8'h60, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
